// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared image geometry, pixel/row types for row buffer and im2col.
// Revision : 1.0
// ============================================================================
package conv_pkg;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 3;
    localparam int DW     = 8;
    localparam int NPOS   = IMG_H - K + 1;

    localparam int AW     = $clog2(NPOS + 1);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int CNT_W  = $clog2(NPOS);
    // One extra bit over the address so that any i_addr + K - 1 stays unwrapped.
    localparam int RIDX_W = AW + 1;

    typedef logic [DW-1:0] pix_t;
    typedef pix_t [IMG_W-1:0] row_t;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/img_bank.sv
`default_nettype none
// ============================================================================
// Module   : img_bank
// Brief    : One IMG_H-row image store, single row write port, K-row read port.
// Revision : 1.0
// ============================================================================
module img_bank
    import conv_pkg::*;
(
    input  logic                             i_clk,
    input  logic                             i_wen,
    input  logic [ROW_W-1:0]                 i_wr_row,
    input  logic [IMG_W-1:0][DW-1:0]         i_wr_data,
    input  logic [AW-1:0]                    i_rd_addr,
    output logic [K-1:0][IMG_W-1:0][DW-1:0]  o_rd_data
);

    row_t r_mem [IMG_H];

    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            r_mem[i_wr_row] <= i_wr_data;
        end
    end

    // Window slots that fall below the last image row read as zero.
    for (genvar gi = 0; gi < K; gi++) begin : g_rd
        logic [RIDX_W-1:0] w_idx;
        assign w_idx = RIDX_W'(i_rd_addr) + RIDX_W'(gi);
        assign o_rd_data[gi] = (w_idx < RIDX_W'(IMG_H)) ? r_mem[w_idx[ROW_W-1:0]] : '0;
    end

endmodule : img_bank
`default_nettype wire

// File: rtl/img_row_buffer.sv
`default_nettype none
// ============================================================================
// Module   : img_row_buffer
// Brief    : Ping-pong two-bank image row store feeding K-row windows to im2col.
// Revision : 1.0
// ============================================================================
module img_row_buffer
    import conv_pkg::*;
(
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_pre_valid,
    output logic                             o_pre_ready,
    input  logic [IMG_W-1:0][DW-1:0]         i_data,
    output logic                             o_post_valid,
    input  logic                             i_post_ready,
    input  logic [AW-1:0]                    i_addr,
    output logic [K-1:0][IMG_W-1:0][DW-1:0]  o_data
);

    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [ROW_W-1:0] r_wr_row;
    logic [CNT_W-1:0] r_rd_cnt;

    logic             w_pre_fire;
    logic             w_post_fire;
    logic             w_wr_last;
    logic             w_rd_last;
    logic [1:0]       w_full_nxt;
    logic [K-1:0][IMG_W-1:0][DW-1:0] w_bank_data [2];

    assign o_pre_ready  = ~r_full[r_wr_bank];
    assign o_post_valid = r_full[r_rd_bank];
    assign w_pre_fire   = i_pre_valid & o_pre_ready;
    assign w_post_fire  = o_post_valid & i_post_ready;
    assign w_wr_last    = w_pre_fire && (r_wr_row == ROW_W'(IMG_H - 1));
    assign w_rd_last    = w_post_fire && (r_rd_cnt == CNT_W'(NPOS - 1));

    // A completing write targets an empty bank and a free targets a full one,
    // so the two updates can never collide on the same bank.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_row  <= '0;
            r_rd_cnt  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_pre_fire) begin
                if (w_wr_last) begin
                    r_wr_row  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_row  <= r_wr_row + 1'b1;
                end
            end
            if (w_post_fire) begin
                if (w_rd_last) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_cnt  <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
        img_bank u_bank (
            .i_clk     (i_clk),
            .i_wen     (w_pre_fire && (r_wr_bank == 1'(gb))),
            .i_wr_row  (r_wr_row),
            .i_wr_data (i_data),
            .i_rd_addr (i_addr),
            .o_rd_data (w_bank_data[gb])
        );
    end

    assign o_data = o_post_valid ? w_bank_data[r_rd_bank] : '0;

endmodule : img_row_buffer
`default_nettype wire

// File: tb/tb_img_row_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_row_buffer
// Brief    : Self-checking bench for img_row_buffer against a row-queue model.
// Revision : 1.0
// ============================================================================
module tb_img_row_buffer;
    import conv_pkg::*;

    logic                             i_clk;
    logic                             i_rst;
    logic                             i_pre_valid;
    logic                             o_pre_ready;
    logic [IMG_W-1:0][DW-1:0]         i_data;
    logic                             o_post_valid;
    logic                             i_post_ready;
    logic [AW-1:0]                    i_addr;
    logic [K-1:0][IMG_W-1:0][DW-1:0]  o_data;

    img_row_buffer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .i_data       (i_data),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .i_addr       (i_addr),
        .o_data       (o_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: every accepted row in arrival order; the first IMG_H rows form the
    // image being read once at least IMG_H rows are held. Two images max.
    row_t m_rows [$];
    int   m_reads = 0;

    typedef struct {
        int addr;
        int row;
        int col;
        int exp;
    } rd_vec_t;

    rd_vec_t tbl [10];

    function automatic row_t pat(int img, int r);
        row_t v;
        for (int c = 0; c < IMG_W; c++) begin
            v[c] = DW'((r * IMG_W + c + img * 53) % 256);
        end
        return v;
    endfunction

    function automatic logic [K-1:0][IMG_W-1:0][DW-1:0] model_data(int addr);
        logic [K-1:0][IMG_W-1:0][DW-1:0] v;
        v = '0;
        if (m_rows.size() >= IMG_H) begin
            for (int r = 0; r < K; r++) begin
                if (addr + r < IMG_H) v[r] = m_rows[addr + r];
            end
        end
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkd(string name, logic [K-1:0][IMG_W-1:0][DW-1:0] act,
                        logic [K-1:0][IMG_W-1:0][DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare outputs against the model, clock once, then advance the model.
    task automatic cycle();
        logic pf;
        logic qf;
        logic rst;
        row_t d;
        #1;
        chk("pre_ready", 32'(o_pre_ready), 32'(m_rows.size() < 2 * IMG_H));
        chk("post_valid", 32'(o_post_valid), 32'(m_rows.size() >= IMG_H));
        chkd("data", o_data, model_data(int'(i_addr)));
        pf  = i_pre_valid && (m_rows.size() < 2 * IMG_H);
        qf  = i_post_ready && (m_rows.size() >= IMG_H);
        rst = i_rst;
        d   = i_data;
        @(posedge i_clk);
        if (rst) begin
            m_rows.delete();
            m_reads = 0;
        end else begin
            if (qf) begin
                m_reads++;
                if (m_reads == NPOS) begin
                    for (int i = 0; i < IMG_H; i++) void'(m_rows.pop_front());
                    m_reads = 0;
                end
            end
            if (pf) m_rows.push_back(d);
        end
        #1;
    endtask

    task automatic write_rows(int img, int first, int n);
        for (int i = 0; i < n; i++) begin
            i_pre_valid = 1'b1;
            i_data      = pat(img, first + i);
            cycle();
        end
        i_pre_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cycle();
        cycle();
        i_rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{5, 0, 0, 140};
        tbl[1] = '{5, 2, 27, 223};
        tbl[2] = '{26, 0, 0, 216};
        tbl[3] = '{26, 1, 27, 15};
        tbl[4] = '{26, 2, 0, 0};
        tbl[5] = '{26, 2, 27, 0};
        tbl[6] = '{25, 2, 0, 244};
        tbl[7] = '{0, 0, 0, 0};
        tbl[8] = '{0, 2, 5, 61};
        tbl[9] = '{24, 2, 3, 219};

        i_rst = 1'b1;
        i_pre_valid = 1'b0;
        i_post_ready = 1'b0;
        i_addr = '0;
        i_data = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_pre_ready", 32'(o_pre_ready), 32'd1);
        chk("rst_post_valid", 32'(o_post_valid), 32'd0);
        chkd("rst_data", o_data, '0);
        i_rst = 1'b0;

        // Fill bank 0, validity appears only after the 28th row.
        write_rows(0, 0, 27);
        #1 chk("t1_not_valid_early", 32'(o_post_valid), 32'd0);
        write_rows(0, 27, 1);
        #1 chk("t1_valid", 32'(o_post_valid), 32'd1);

        for (int i = 0; i < 10; i++) begin
            i_addr = AW'(tbl[i].addr);
            #1 chk("tbl_pix", 32'(o_data[tbl[i].row][tbl[i].col]), 32'(tbl[i].exp));
            cycle();
        end

        // 25 fires keep the bank, the 26th frees it.
        i_addr = AW'(3);
        i_post_ready = 1'b1;
        repeat (25) cycle();
        i_post_ready = 1'b0;
        #1 chk("t2_hold_valid", 32'(o_post_valid), 32'd1);
        repeat (2) cycle();
        #1 chk("t2_still_valid", 32'(o_post_valid), 32'd1);
        i_post_ready = 1'b1;
        cycle();
        i_post_ready = 1'b0;
        #1 chk("t2_freed", 32'(o_post_valid), 32'd0);
        chk("t2_pre_ready", 32'(o_pre_ready), 32'd1);

        // Both banks full, a held row waits until bank 0 is freed.
        do_reset();
        write_rows(0, 0, 28);
        write_rows(1, 0, 28);
        #1 chk("t3_full", 32'(o_pre_ready), 32'd0);
        i_pre_valid = 1'b1;
        i_data = pat(3, 0);
        repeat (3) cycle();
        i_post_ready = 1'b1;
        repeat (26) cycle();
        i_post_ready = 1'b0;
        #1 chk("t3_ready_after_free", 32'(o_pre_ready), 32'd1);
        cycle();
        i_pre_valid = 1'b0;
        i_post_ready = 1'b1;
        repeat (26) cycle();
        i_post_ready = 1'b0;
        write_rows(3, 1, 27);
        i_addr = '0;
        #1 chk("t3_held_row_c0", 32'(o_data[0][0]), 32'd159);
        chk("t3_held_row_c27", 32'(o_data[0][27]), 32'd186);
        chk("t3_next_row", 32'(o_data[1][0]), 32'd187);
        cycle();

        // Final write of bank 1 coincides with the freeing read of bank 0.
        do_reset();
        write_rows(0, 0, 28);
        write_rows(1, 0, 27);
        i_post_ready = 1'b1;
        repeat (25) cycle();
        i_pre_valid = 1'b1;
        i_data = pat(1, 27);
        cycle();
        i_pre_valid = 1'b0;
        i_post_ready = 1'b0;
        #1 chk("t5_post_valid", 32'(o_post_valid), 32'd1);
        chk("t5_pre_ready", 32'(o_pre_ready), 32'd1);
        i_addr = AW'(25);
        #1 chk("t5_last_row", 32'(o_data[2][0]), 32'd41);
        chk("t5_row25", 32'(o_data[0][0]), 32'd241);
        i_addr = '0;
        #1 chk("t5_row0", 32'(o_data[0][0]), 32'd53);
        cycle();

        // Reset mid-image discards the partial rows.
        do_reset();
        write_rows(0, 0, 10);
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        #1 chk("t6_pre_ready", 32'(o_pre_ready), 32'd1);
        chk("t6_post_valid", 32'(o_post_valid), 32'd0);
        chkd("t6_data", o_data, '0);
        write_rows(2, 0, 27);
        #1 chk("t6_not_valid_early", 32'(o_post_valid), 32'd0);
        write_rows(2, 27, 1);
        #1 chk("t6_valid", 32'(o_post_valid), 32'd1);
        chk("t6_row0", 32'(o_data[0][0]), 32'd106);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            i_pre_valid  = ($urandom_range(0, 99) < 60);
            i_post_ready = ($urandom_range(0, 99) < 50);
            i_addr       = AW'($urandom_range(0, 31));
            for (int c = 0; c < IMG_W; c++) i_data[c] = DW'($urandom);
            i_rst        = ($urandom_range(0, 499) == 0);
            cycle();
        end
        i_rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_img_row_buffer
`default_nettype wire
